// File: rtl/debug_trace_buffer.sv
// rtl/debug_trace_buffer.sv - CPU state snapshot FIFO streamed out as five 16-bit words per entry
module debug_trace_buffer #(
    parameter int          DEPTH       = 8,
    parameter int          ADDR_W      = 3,
    parameter logic [4:0]  FETCH_STATE = 5'd0
) (
    input  logic              CLK,
    input  logic              RstN,
    input  logic              CaptureEn,
    input  logic [4:0]        CurrentState,
    input  logic [15:0]       PCIn,
    input  logic [15:0]       MSPIn,
    input  logic [15:0]       RSPIn,
    input  logic [15:0]       ValAIn,
    input  logic [15:0]       ValBIn,
    input  logic              ReadReady,
    output logic              ReadValid,
    output logic [15:0]       ReadData,
    output logic              ReadLast,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    input  logic              ClearOverflow
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_COUNT  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR    = ADDR_W'(1);
    localparam logic [2:0]        LAST_WORD  = 3'd4;

    logic [79:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [2:0]        word_idx;
    logic [4:0]        prev_state;
    logic              trigger;
    logic              xfer;
    logic              pop;
    logic              accept;
    logic              drop;
    logic [79:0]       head;
    logic [15:0]       word_mux;

    // Capture only on the cycle the control unit enters fetch, not while it stays there.
    assign trigger   = CaptureEn && (CurrentState == FETCH_STATE) && (prev_state != FETCH_STATE);
    assign ReadValid = (Count != '0);
    assign xfer      = ReadValid && ReadReady;
    assign pop       = xfer && (word_idx == LAST_WORD);
    // A full buffer still takes the snapshot when the head entry leaves on the same edge.
    assign accept    = trigger && ((Count != FULL_COUNT) || pop);
    assign drop      = trigger && !accept;

    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wptr] <= {PCIn, MSPIn, RSPIn, ValAIn, ValBIn};
        end
    end

    always_ff @(posedge CLK or negedge RstN) begin
        if (!RstN) begin
            wptr       <= '0;
            rptr       <= '0;
            word_idx   <= '0;
            Count      <= '0;
            Overflow   <= 1'b0;
            prev_state <= 5'd31;
        end else begin
            prev_state <= CurrentState;
            if (accept) begin
                wptr <= wptr + ONE_PTR;
            end
            if (xfer) begin
                if (pop) begin
                    word_idx <= '0;
                    rptr     <= rptr + ONE_PTR;
                end else begin
                    word_idx <= word_idx + 3'd1;
                end
            end
            if (accept && !pop) begin
                Count <= Count + ONE_COUNT;
            end else if (pop && !accept) begin
                Count <= Count - ONE_COUNT;
            end
            if (drop) begin
                Overflow <= 1'b1;
            end else if (ClearOverflow) begin
                Overflow <= 1'b0;
            end
        end
    end

    assign head = mem[rptr];

    always_comb begin
        word_mux = '0;
        case (word_idx)
            3'd0:    word_mux = head[79:64];
            3'd1:    word_mux = head[63:48];
            3'd2:    word_mux = head[47:32];
            3'd3:    word_mux = head[31:16];
            3'd4:    word_mux = head[15:0];
            default: word_mux = '0;
        endcase
    end

    // Gating hides the unreset memory contents while the buffer is empty.
    assign ReadData = ReadValid ? word_mux : '0;
    assign ReadLast = ReadValid && (word_idx == LAST_WORD);

endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Snapshot capture unit for the JALA CPU debug path.
- Samples CPU architectural state (PC, MSP, RSP, ValA, ValB) each time the control unit enters the fetch state.
- Buffers each snapshot in a small FIFO and streams it out to a host reader as five 16-bit words over a valid/ready handshake.
- Sits beside stage7FullIntegration and consumes its observation outputs, so hardware can read out a run that a simulation bench would otherwise watch.

Parameters:
- DEPTH, 8, number of snapshot entries; power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).
- FETCH_STATE, 5'd0, CurrentState encoding that marks instruction fetch.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RstN  input  1  asynchronous active-low reset.
- CaptureEn  input  1  enables snapshot capture.
- CurrentState  input  5  control unit current state.
- PCIn  input  16  CPU PC.
- MSPIn  input  16  main stack pointer.
- RSPIn  input  16  return stack pointer.
- ValAIn  input  16  ValA register.
- ValBIn  input  16  ValB register.
- ReadReady  input  1  host accepts ReadData this cycle.
- ReadValid  output  1  ReadData holds a valid word.
- ReadData  output  16  current word of the head entry.
- ReadLast  output  1  current word is word 4 (ValB) of its entry.
- Count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- Overflow  output  1  sticky; a snapshot was dropped.
- ClearOverflow  input  1  synchronous clear of Overflow.

Behaviour:
- Reset (RstN=0, asynchronous):
  - Write pointer, read pointer, Count and word index are 0.
  - Overflow=0 and the registered PrevState is 5'd31.
  - ReadValid=0 and ReadLast=0. ReadData is don't-care but reads 0, since the memory is not reset and the mux output is gated with ReadValid.
  - Reset during readout discards all entries and the partial word index.
- Capture trigger:
  - Trigger = CaptureEn and CurrentState==FETCH_STATE and PrevState!=FETCH_STATE, where PrevState is CurrentState registered every cycle.
  - One snapshot is taken per fetch entry. A state held at FETCH_STATE for several cycles captures once.
- Push:
  - On a trigger edge, if the entry is accepted, write {PCIn, MSPIn, RSPIn, ValAIn, ValBIn}, as sampled at that edge, to mem[wptr].
  - Then wptr++ (wraps mod DEPTH) and Count++.
- Full:
  - The entry is accepted if Count<DEPTH, or if Count==DEPTH and a pop completes on the same edge.
  - Otherwise the snapshot is dropped, Overflow is set to 1, and pointers and Count are unchanged.
- Overflow:
  - Stays 1 until ClearOverflow is sampled high.
  - If a set and ClearOverflow occur on the same edge, set wins and Overflow=1.
- Read sequencer:
  - A 3-bit word index selects ReadData: 0=PC, 1=MSP, 2=RSP, 3=ValA, 4=ValB.
  - ReadData is combinational from mem[rptr] and the index.
  - ReadValid = (Count!=0).
  - ReadLast = ReadValid and index==4.
- Handshake:
  - A transfer occurs when ReadValid and ReadReady are both high at a rising edge.
  - For index<4, the transfer does index++.
  - For index==4, the transfer pops: index=0, rptr++ (wraps mod DEPTH), Count--.
  - With ReadValid=0, ReadReady is ignored.
  - ReadData must stay stable while ReadValid=1 and ReadReady=0.
- Simultaneous push and pop: Count is unchanged and both pointers advance.
- Latency: a snapshot captured at edge N into an empty buffer gives ReadValid=1 after edge N, with PC presented.
- Throughput: one word per cycle, so one entry per 5 cycles when ReadReady is held high.
- Width: Count is ADDR_W+1 bits so it can represent DEPTH. Pointers are ADDR_W bits and wrap naturally.

Test Plan:
1. Single capture: CaptureEn=1, CurrentState 3→0 with PC=16'h0010, MSP=16'h7FFE, RSP=16'h3FFE, ValA=16'h0005, ValB=16'h0009, ReadReady=1 → over 5 cycles ReadData = 0010, 7FFE, 3FFE, 0005, 0009; ReadLast only on 0009; Count returns to 0.
2. Held fetch state: CurrentState=0 for 4 cycles, then 2, then 0 again → exactly 2 entries, Count=2.
3. Overflow: 9 fetch entries with ReadReady=0 and PC=1..9 → Count=8 and Overflow=1; readout yields PC 1..8 in order; ClearOverflow pulse gives Overflow=0.
4. Backpressure: entry stored, ReadReady toggles 1,0,0,1,1,0,1,1 → words advance only on ready cycles, with ReadData stable during stalls.
5. Full with simultaneous pop: Count=8, index=4, ReadReady=1, and a fetch entry on the same edge → entry accepted, Count stays 8, Overflow=0.
6. Async reset mid-readout: RstN low at index=2 with Count=3 → immediately ReadValid=0 and Count=0; after release a new capture reads from PC (index 0).
